// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file writeback arbiter. The ALU pipeline has strict
//               priority. Mult/div results wait in a 2-entry in-order buffer
//               and drain in idle slots. An optional starvation guard
//               (enabled by WB_STARVE_GUARD_EN) asks upstream to stall.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        reg_write,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic [31:0] busy_mask,
    output logic        stall_req
);

    // Slot 0 is always the head; slot 1 is valid only if slot 0 is valid.
    logic        r_v0, r_v1;
    logic [4:0]  r_a0, r_a1;
    logic [31:0] r_d0, r_d1;

    logic        r_reg_write;
    logic [4:0]  r_write_addr;
    logic [31:0] r_write_data;
    logic [31:0] r_busy;

    logic        w_push;
    logic        w_alu_grant;
    logic        w_fifo_grant;
    logic        w_keep0, w_keep1;
    logic        w_n_v0, w_n_v1;
    logic [4:0]  w_n_a0, w_n_a1;
    logic [31:0] w_n_d0, w_n_d1;
    logic [31:0] w_busy_next;

    assign md_ready     = ~(r_v0 & r_v1);
    assign w_push       = md_valid & md_ready & (md_addr != 5'd0);
    assign w_alu_grant  = alu_valid & (alu_addr != 5'd0);
    assign w_fifo_grant = ~w_alu_grant & r_v0;

    // Entries surviving this edge: not popped and not overwritten by the ALU.
    assign w_keep0 = r_v0 & ~w_fifo_grant & ~(w_alu_grant & (r_a0 == alu_addr));
    assign w_keep1 = r_v1 & ~(w_alu_grant & (r_a1 == alu_addr));

    always_comb begin
        w_n_v0 = 1'b0;
        w_n_a0 = r_a0;
        w_n_d0 = r_d0;
        w_n_v1 = 1'b0;
        w_n_a1 = r_a1;
        w_n_d1 = r_d1;
        if (w_keep0) begin
            w_n_v0 = 1'b1;
        end else if (w_keep1) begin
            w_n_v0 = 1'b1;
            w_n_a0 = r_a1;
            w_n_d0 = r_d1;
        end else if (w_push) begin
            w_n_v0 = 1'b1;
            w_n_a0 = md_addr;
            w_n_d0 = md_data;
        end
        // A push into a full buffer is impossible, so two survivors exclude it.
        if (w_keep0 && w_keep1) begin
            w_n_v1 = 1'b1;
        end else if ((w_keep0 || w_keep1) && w_push) begin
            w_n_v1 = 1'b1;
            w_n_a1 = md_addr;
            w_n_d1 = md_data;
        end
    end

    always_comb begin
        w_busy_next = 32'd0;
        if (w_n_v0) w_busy_next = w_busy_next | (32'd1 << w_n_a0);
        if (w_n_v1) w_busy_next = w_busy_next | (32'd1 << w_n_a1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_a0 <= 5'd0;
            r_a1 <= 5'd0;
            r_d0 <= 32'd0;
            r_d1 <= 32'd0;
            r_busy <= 32'd0;
        end else begin
            r_v0 <= w_n_v0;
            r_v1 <= w_n_v1;
            r_a0 <= w_n_a0;
            r_a1 <= w_n_a1;
            r_d0 <= w_n_d0;
            r_d1 <= w_n_d1;
            r_busy <= w_busy_next;
        end
    end

    // Address and data hold their last values across idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 32'd0;
        end else begin
            r_reg_write <= w_alu_grant | w_fifo_grant;
            if (w_alu_grant) begin
                r_write_addr <= alu_addr;
                r_write_data <= alu_data;
            end else if (w_fifo_grant) begin
                r_write_addr <= r_a0;
                r_write_data <= r_d0;
            end
        end
    end

    assign reg_write  = r_reg_write;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign busy_mask  = r_busy;

`ifdef WB_STARVE_GUARD_EN
    localparam int c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               r_stall;

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_fifo_grant || !w_n_v0) begin
            w_cnt_next = '0;
        end else if (w_alu_grant && r_v0 && (r_cnt != c_limit)) begin
            w_cnt_next = r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_stall <= (w_cnt_next == c_limit);
        end
    end

    assign stall_req = r_stall;
`else
    logic w_unused_limit;
    assign w_unused_limit = (STARVE_LIMIT != 0);
    assign stall_req      = 1'b0;
`endif

endmodule
`default_nettype wire
